// File: rtl/mdu_if.sv
// Handshake and result bundle between the EX stage and the iterative multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             dbz;

   modport master (output start, op, a, b, input busy, done, hi, lo, dbz);
   modport slave  (input start, op, a, b, output busy, done, hi, lo, dbz);
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign correction in a final cycle.
module mdu_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic clk,
   input logic rst,
   mdu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;    // mult: {partial, multiplier}; div: low half holds dividend/quotient
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   opnd;   // mult: multiplicand magnitude; div: divisor magnitude
   logic               is_div, sign_q, sign_r;
   logic [WIDTH-1:0]   hi, lo;
   logic               done, dbz;

   logic               neg_a, neg_b, ge, last;
   logic [WIDTH-1:0]   mag_a, mag_b, q_f, r_f;
   logic [WIDTH:0]     mul_sum, shifted, diff;
   logic [2*WIDTH-1:0] prod_f;

   always_comb begin
      neg_a   = ~bus.op[0] & bus.a[WIDTH-1];
      neg_b   = ~bus.op[0] & bus.b[WIDTH-1];
      mag_a   = neg_a ? -bus.a : bus.a;
      mag_b   = neg_b ? -bus.b : bus.b;
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
      shifted = {rem[WIDTH-1:0], acc[WIDTH-1]};
      // rem < divisor keeps |diff| below 2^WIDTH, so bit WIDTH is a clean borrow
      diff    = shifted - {1'b0, opnd};
      ge      = ~diff[WIDTH];
      last    = (cnt == CNT_W'(WIDTH - 1));
      prod_f  = sign_q ? -acc : acc;
      q_f     = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      r_f     = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         rem    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         dbz    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               case (bus.op)
                  3'b000, 3'b001, 3'b010, 3'b011: begin
                     dbz    <= 1'b0;
                     cnt    <= '0;
                     rem    <= '0;
                     is_div <= bus.op[1];
                     sign_q <= neg_a ^ neg_b;
                     sign_r <= neg_a;
                     if (!bus.op[1]) begin
                        acc   <= {{WIDTH{1'b0}}, mag_b};
                        opnd  <= mag_a;
                        state <= MUL;
                     end else begin
                        acc  <= {{WIDTH{1'b0}}, mag_a};
                        opnd <= mag_b;
                        if (bus.b == '0) begin
                           dbz   <= 1'b1;
                           state <= FIN;
                        end else begin
                           state <= DIV;
                        end
                     end
                  end
                  3'b100: begin
                     hi  <= bus.a;
                     dbz <= 1'b0;
                  end
                  3'b101: begin
                     lo  <= bus.a;
                     dbz <= 1'b0;
                  end
                  default: ;
               endcase
            end
            MUL: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (last) state <= FIN;
            end
            DIV: begin
               rem             <= ge ? diff : shifted;
               acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], ge};
               cnt             <= cnt + 1'b1;
               if (last) state <= FIN;
            end
            FIN: begin
               done  <= 1'b1;
               state <= IDLE;
               if (!dbz) begin
                  if (is_div) begin
                     lo <= q_f;
                     hi <= r_f;
                  end else begin
                     {hi, lo} <= prod_f;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done;
   assign bus.hi   = hi;
   assign bus.lo   = lo;
   assign bus.dbz  = dbz;
endmodule
